// File: rtl/dm_arbiter.sv
// dm_arbiter: shared data-memory responder for the multi-core array.
// Grants one core per access in round-robin order, serves it from a single
// synchronous DEPTH x 16 memory, and broadcasts a global halt once every
// core has signalled end_process.
module dm_arbiter #(
    parameter int unsigned NCORES = 4,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCORES-1:0]     core_req,
    input  logic [NCORES-1:0]     core_we,
    input  logic [NCORES*16-1:0]  core_addr,
    input  logic [NCORES*16-1:0]  core_wdata,
    input  logic [NCORES-1:0]     core_end,
    output logic [15:0]           dm_rdata,
    output logic [2*NCORES-1:0]   core_status,
    output logic                  all_done
);

    localparam int unsigned DW = 16;
    localparam int unsigned IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    localparam logic [1:0] STAT_RUN  = 2'b00;
    localparam logic [1:0] STAT_WAIT = 2'b01;
    localparam logic [1:0] STAT_ACK  = 2'b10;
    localparam logic [1:0] STAT_HALT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_HALT
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        win_q, win_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic [2*NCORES-1:0]  status_q, status_d;
    logic                 all_done_q, all_done_d;
    logic [NCORES-1:0]    done_q, done_d;

    logic [NCORES-1:0]    elig_c;
    logic                 all_done_c;
    logic                 grant_vld_c;
    logic [IW-1:0]        grant_idx_c;
    logic [IW-1:0]        rr_cand_c;

    logic [DW-1:0]        mem_q [DEPTH];

    // Upper address bits are deliberately ignored: addresses wrap modulo DEPTH.
    logic                 unused_addr_c;
    assign unused_addr_c = ^core_addr;

    // Sticky done flags include this cycle's end strobes so halt and RUN
    // status take effect one cycle after core_end rises.
    always_comb begin
        done_d     = done_q | core_end;
        elig_c     = core_req & ~done_d;
        all_done_c = &done_d;
    end

    // Round-robin pick: first eligible core starting at last+1.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        rr_cand_c   = '0;
        for (int unsigned k = 1; k <= NCORES; k++) begin
            rr_cand_c = IW'((32'(last_q) + k) % NCORES);
            if (!grant_vld_c && elig_c[rr_cand_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = rr_cand_c;
            end
        end
    end

    // Next-state, access latch and registered status computation.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        status_d   = '0;
        all_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (all_done_c) begin
                    state_d = S_HALT;
                end else if (grant_vld_c) begin
                    state_d = S_ACCESS;
                    win_d   = grant_idx_c;
                    we_d    = core_we[grant_idx_c];
                    addr_d  = core_addr[DW*grant_idx_c +: AW];
                    wdata_d = core_wdata[DW*grant_idx_c +: DW];
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                rdata_d = we_q ? wdata_q : mem_q[addr_q];
            end
            S_RESP: begin
                last_d  = win_q;
                state_d = all_done_c ? S_HALT : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        all_done_d = (state_d == S_HALT);
        for (int unsigned i = 0; i < NCORES; i++) begin
            if (state_d == S_HALT) begin
                status_d[2*i +: 2] = STAT_HALT;
            end else if (state_d == S_RESP && win_q == IW'(i)) begin
                status_d[2*i +: 2] = STAT_ACK;
            end else if (elig_c[i]) begin
                status_d[2*i +: 2] = STAT_WAIT;
            end else begin
                status_d[2*i +: 2] = STAT_RUN;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            last_q     <= IW'(NCORES - 1);
            win_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            status_q   <= '0;
            all_done_q <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            status_q   <= status_d;
            all_done_q <= all_done_d;
            done_q     <= done_d;
        end
    end

    // Memory write; not gated by reset so a write in flight still lands.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && we_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign dm_rdata    = rdata_q;
    assign core_status = status_q;
    assign all_done    = all_done_q;

endmodule
